// File: rtl/vec_port_arbiter.sv
// Arbiter sharing the 128-bit data-memory port B between the processor vector path and the audio DMA.
// Define ARB_STATS_EN to add the conflict_cnt / forced_cnt statistics outputs.
module vec_port_arbiter #(
    parameter int AW        = 10,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [127:0]  p_wdata,
    output logic          p_stall,
    output logic          p_rvalid,
    output logic [127:0]  p_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_lock,
    input  logic [AW-1:0] d_addr,
    input  logic [127:0]  d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [127:0]  d_rdata,
`ifdef ARB_STATS_EN
    output logic [15:0]   conflict_cnt,
    output logic [15:0]   forced_cnt,
`endif
    output logic [AW-1:0] mem_addr,
    output logic [127:0]  mem_data,
    output logic          mem_wren,
    input  logic [127:0]  mem_q
);

    localparam int WW = ($clog2(MAX_WAIT + 1) < 3) ? 3 : $clog2(MAX_WAIT + 1);
    localparam int BW = ($clog2(BURST_MAX + 1) < 1) ? 1 : $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    logic [WW-1:0] wait_cnt;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] beat_inc;
    logic          burst_active;
    logic          force_p;
    owner_t        rd_owner;
    logic [127:0]  p_rdata_q;
    logic [127:0]  d_rdata_q;
    logic          hold_cond;
    logic          starve_cond;
    logic          p_win;
    logic          d_win;

    assign hold_cond   = d_req && burst_active && (beat_cnt < BW'(BURST_MAX));
    // Right after a maximal burst the processor gets its turn regardless of wait_cnt.
    assign starve_cond = d_req && !force_p && (wait_cnt == WW'(MAX_WAIT));
    assign beat_inc    = (burst_active ? beat_cnt : '0) + BW'(1);

    always_comb begin
        p_win = 1'b0;
        d_win = 1'b0;
        if (reset) begin
            if (hold_cond || starve_cond) d_win = 1'b1;
            else if (p_req)               p_win = 1'b1;
            else if (d_req)               d_win = 1'b1;
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        if (p_win) begin
            mem_addr = p_addr;
            mem_data = p_wdata;
            mem_wren = p_we;
        end else if (d_win) begin
            mem_addr = d_addr;
            mem_data = d_wdata;
            mem_wren = d_we;
        end
    end

    assign p_stall = p_req && !p_win;
    assign d_gnt   = d_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt     <= '0;
            beat_cnt     <= '0;
            burst_active <= 1'b0;
            force_p      <= 1'b0;
        end else begin
            if (!d_req || d_win)
                wait_cnt <= '0;
            else if (wait_cnt != WW'(MAX_WAIT))
                wait_cnt <= wait_cnt + WW'(1);

            force_p <= 1'b0;
            if (!d_req) begin
                burst_active <= 1'b0;
                beat_cnt     <= '0;
            end else if (d_win) begin
                if (!d_lock) begin
                    burst_active <= 1'b0;
                    beat_cnt     <= '0;
                end else if (beat_inc >= BW'(BURST_MAX)) begin
                    burst_active <= 1'b0;
                    beat_cnt     <= '0;
                    force_p      <= 1'b1;
                end else begin
                    burst_active <= 1'b1;
                    beat_cnt     <= beat_inc;
                end
            end
        end
    end

    // Read return stage: mem_q arrives one cycle after the grant, routed by rd_owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_owner  <= OWN_NONE;
            p_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (p_win && !p_we)      rd_owner <= OWN_P;
            else if (d_win && !d_we) rd_owner <= OWN_D;
            else                     rd_owner <= OWN_NONE;
            if (rd_owner == OWN_P) p_rdata_q <= mem_q;
            if (rd_owner == OWN_D) d_rdata_q <= mem_q;
        end
    end

    assign p_rvalid = (rd_owner == OWN_P);
    assign d_rvalid = (rd_owner == OWN_D);
    assign p_rdata  = p_rvalid ? mem_q : p_rdata_q;
    assign d_rdata  = d_rvalid ? mem_q : d_rdata_q;

`ifdef ARB_STATS_EN
    logic starve_win;
    assign starve_win = reset && starve_cond && !hold_cond;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= '0;
            forced_cnt   <= '0;
        end else begin
            if (p_req && d_req && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;
            if (starve_win && (forced_cnt != 16'hFFFF))
                forced_cnt <= forced_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vec_port_arbiter.sv
// Directed bench for vec_port_arbiter: reset, read routing, starvation, bursts, reset mid-burst.
module tb_vec_port_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          p_req, p_we;
    logic [AW-1:0] p_addr;
    logic [127:0]  p_wdata;
    logic          p_stall, p_rvalid;
    logic [127:0]  p_rdata;
    logic          d_req, d_we, d_lock;
    logic [AW-1:0] d_addr;
    logic [127:0]  d_wdata;
    logic          d_gnt, d_rvalid;
    logic [127:0]  d_rdata;
    logic [AW-1:0] mem_addr;
    logic [127:0]  mem_data;
    logic          mem_wren;
    logic [127:0]  mem_q;
`ifdef ARB_STATS_EN
    logic [15:0]   conflict_cnt;
    logic [15:0]   forced_cnt;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] QX = 128'hA5A5_0000_1111_2222_3333_4444_5555_0005;
    localparam logic [127:0] Q1 = 128'h0101_0101_0101_0101_0101_0101_0101_0101;
    localparam logic [127:0] Q2 = 128'h0202_0202_0202_0202_0202_0202_0202_0202;
    localparam logic [127:0] Q3 = 128'h0303_0303_0303_0303_0303_0303_0303_0303;
    localparam logic [127:0] Q4 = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_0004;
    localparam logic [127:0] QJ = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;

    vec_port_arbiter #(.AW(AW), .MAX_WAIT(4), .BURST_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef ARB_STATS_EN
        .conflict_cnt(conflict_cnt), .forced_cnt(forced_cnt),
`endif
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        p_req = 1'b1; p_we = 1'b1; p_addr = 10'd7; p_wdata = 128'h1234;
        d_req = 1'b1; d_we = 1'b1; d_lock = 1'b0; d_addr = 10'd9; d_wdata = 128'h5678;
        mem_q = '0;

        // Held in reset: grant logic idle, read path cleared
        cyc(); #1;
        chk("rst_p_stall", p_stall, 1'b1);
        chk("rst_d_gnt", d_gnt, 1'b0);
        chk("rst_mem_wren", mem_wren, 1'b0);
        chk("rst_mem_addr", mem_addr, 10'd0);
        chk("rst_p_rvalid", p_rvalid, 1'b0);
        chk("rst_d_rvalid", d_rvalid, 1'b0);
        chk("rst_p_rdata", p_rdata, 128'd0);
        chk("rst_d_rdata", d_rdata, 128'd0);

        // First processor read after reset
        cyc();
        reset = 1'b1; p_req = 1'b1; p_we = 1'b0; p_addr = 10'd5; d_req = 1'b0;
        #1;
        chk("rd5_p_stall", p_stall, 1'b0);
        chk("rd5_mem_addr", mem_addr, 10'd5);
        chk("rd5_mem_wren", mem_wren, 1'b0);
        cyc();
        p_req = 1'b0; mem_q = QX;
        #1;
        chk("rd5_p_rvalid", p_rvalid, 1'b1);
        chk("rd5_p_rdata", p_rdata, QX);
        chk("rd5_d_rvalid", d_rvalid, 1'b0);
        chk("idle_mem_addr", mem_addr, 10'd0);
        chk("idle_mem_data", mem_data, 128'd0);
        cyc();
        mem_q = QJ;
        #1;
        chk("rd5_p_rvalid_drop", p_rvalid, 1'b0);
        chk("rd5_p_rdata_hold", p_rdata, QX);

        // Continuous contention: DMA forced in every fifth cycle
        for (int i = 0; i < 10; i++) begin
            cyc();
            p_req = 1'b1; p_we = 1'b1; p_addr = 10'd7;
            d_req = 1'b1; d_we = 1'b1; d_lock = 1'b0; d_addr = 10'd9;
            #1;
            chk($sformatf("starve_d_gnt_%0d", i), d_gnt, (i % 5 == 4));
            chk($sformatf("starve_p_stall_%0d", i), p_stall, (i % 5 == 4));
            chk($sformatf("starve_addr_%0d", i), mem_addr, (i % 5 == 4) ? 10'd9 : 10'd7);
        end
        cyc();
        p_req = 1'b0; d_req = 1'b0;

        // Locked burst: starvation grant opens an 8-beat burst, then processor gets one cycle
        for (int i = 0; i < 13; i++) begin
            cyc();
            p_req = 1'b1; p_we = 1'b1; d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1;
            #1;
            chk($sformatf("burst_d_gnt_%0d", i), d_gnt, (i >= 4 && i <= 11));
            chk($sformatf("burst_p_stall_%0d", i), p_stall, (i >= 4 && i <= 11));
        end
        cyc();
        p_req = 1'b0;
        #1;
        chk("burst_resume_d_gnt", d_gnt, 1'b1);

        // Alternating reads P(1), D(2), P(3)
        cyc();
        d_req = 1'b0; d_lock = 1'b0; p_req = 1'b1; p_we = 1'b0; p_addr = 10'd1;
        #1;
        chk("alt_a_p_stall", p_stall, 1'b0);
        chk("alt_a_addr", mem_addr, 10'd1);
        cyc();
        p_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd2; mem_q = Q1;
        #1;
        chk("alt_b_p_rvalid", p_rvalid, 1'b1);
        chk("alt_b_p_rdata", p_rdata, Q1);
        chk("alt_b_d_rvalid", d_rvalid, 1'b0);
        chk("alt_b_d_gnt", d_gnt, 1'b1);
        chk("alt_b_addr", mem_addr, 10'd2);
        cyc();
        d_req = 1'b0; p_req = 1'b1; p_addr = 10'd3; mem_q = Q2;
        #1;
        chk("alt_c_d_rvalid", d_rvalid, 1'b1);
        chk("alt_c_d_rdata", d_rdata, Q2);
        chk("alt_c_p_rvalid", p_rvalid, 1'b0);
        chk("alt_c_p_rdata_hold", p_rdata, Q1);
        chk("alt_c_addr", mem_addr, 10'd3);
        cyc();
        p_req = 1'b0; mem_q = Q3;
        #1;
        chk("alt_d_p_rvalid", p_rvalid, 1'b1);
        chk("alt_d_p_rdata", p_rdata, Q3);
        chk("alt_d_d_rvalid", d_rvalid, 1'b0);
        chk("alt_d_d_rdata_hold", d_rdata, Q2);

        // Reset during a locked DMA read burst
        cyc();
        d_req = 1'b1; d_lock = 1'b1; d_we = 1'b0; d_addr = 10'd4;
        #1;
        chk("rb_e_d_gnt", d_gnt, 1'b1);
        chk("rb_e_addr", mem_addr, 10'd4);
        cyc();
        mem_q = Q4;
        #1;
        chk("rb_f_d_gnt", d_gnt, 1'b1);
        chk("rb_f_d_rvalid", d_rvalid, 1'b1);
        chk("rb_f_d_rdata", d_rdata, Q4);
        reset = 1'b0;
        #1;
        chk("rb_rst_d_gnt", d_gnt, 1'b0);
        chk("rb_rst_d_rvalid", d_rvalid, 1'b0);
        chk("rb_rst_mem_wren", mem_wren, 1'b0);
        chk("rb_rst_mem_addr", mem_addr, 10'd0);
        chk("rb_rst_d_rdata", d_rdata, 128'd0);
        cyc();
        mem_q = QJ;
        #1;
        chk("rb_g_d_rvalid", d_rvalid, 1'b0);
        reset = 1'b1; p_req = 1'b1; p_we = 1'b1; p_addr = 10'd6; d_we = 1'b1;
        #1;
        chk("rb_post_p_stall", p_stall, 1'b0);
        chk("rb_post_d_gnt", d_gnt, 1'b0);
        chk("rb_post_addr", mem_addr, 10'd6);
        cyc();
        #1;
        chk("rb_h_d_rvalid", d_rvalid, 1'b0);
        chk("rb_h_p_rvalid", p_rvalid, 1'b0);

`ifdef ARB_STATS_EN
        // Statistics: ten cycles of contention
        cyc();
        reset = 1'b0; p_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
        #1;
        chk("stat_rst_conflict", conflict_cnt, 16'd0);
        chk("stat_rst_forced", forced_cnt, 16'd0);
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            p_req = 1'b1; d_req = 1'b1;
        end
        cyc();
        p_req = 1'b0; d_req = 1'b0;
        #1;
        chk("stat_conflict", conflict_cnt, 16'd10);
        chk("stat_forced", forced_cnt, 16'd2);
`endif

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
